fetch_queue: RTL
================

# fetch_queue

Parametrised successor to the single-register fetch stage. It runs a request FSM on the instruction bus (ibus_req_t/ibus_resp_t) and buffers returned instructions in a QDEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. Branch redirects flush the FIFO and squash any in-flight response, so decode stalls no longer stall the bus, and vice versa.

## Interface
- RESET_PC, 64'h8000_0000: first fetch address after reset.
- QDEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ireq  out  ibus_req_t  fetch request (valid, addr).
- iresp  in  ibus_resp_t  bus response (data_ok, data[31:0]).
- redirect  in  1  branch/redirect taken this cycle.
- redirect_pc  in  64  redirect target.
- dataF  out  fetch_data_t  FIFO head (valid, pc, raw_instr).
- deq_ready  in  1  decode accepts dataF this cycle.
- occupancy  out  $clog2(QDEPTH+1)  current FIFO count.

## Operation
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
  - state: IDLE / REQ / DROP.
  - FIFO head/tail pointers (wrap mod QDEPTH) and count.
- ireq.valid = (state != IDLE). ireq.addr = req_addr. Addr is held stable until data_ok.
- One outstanding request at a time. A request is only issued when count < QDEPTH, which reserves its slot.
- IDLE:
  - If redirect: pc <= redirect_pc, req_addr <= redirect_pc, go REQ.
  - Else if count < QDEPTH: req_addr <= pc, go REQ.
- REQ, data_ok, no redirect:
  - Enqueue {pc=req_addr, raw_instr=iresp.data}.
  - pc <= req_addr+4.
  - If count_next < QDEPTH: req_addr <= req_addr+4, stay REQ. Else go IDLE.
- REQ, redirect with data_ok in the same cycle: discard the response, req_addr <= pc <= redirect_pc, stay REQ.
- REQ, redirect without data_ok: pc <= redirect_pc, go DROP; req_addr is unchanged.
- DROP:
  - On data_ok: discard, req_addr <= pc, go REQ.
  - A further redirect while in DROP only updates pc.
- FIFO:
  - dataF.valid = (count != 0); dataF fields come from the head.
  - Dequeue when dataF.valid && deq_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Enqueue never occurs when full; dequeue never occurs when empty.
- Redirect flushes the FIFO: count <= 0, pointers <= 0.
  - A dequeue handshake in the redirect cycle is still delivered.
  - The flush has priority over enqueue.
- pc+4 wraps mod 2^64. Address bits [1:0] pass through unchecked.

## Timing
- Reset values:
  - ireq.valid=0, ireq.addr=RESET_PC.
  - dataF.valid=0, dataF.pc=0, dataF.raw_instr=0, occupancy=0.
  - pc=RESET_PC, state=IDLE.
- Reset asserted mid-operation clears everything immediately, including an outstanding request. The bus is reset with this block.
- Reset release edge E: ireq.valid=1 with addr=RESET_PC after edge E+1.
- Back-to-back fetch: with data_ok at cycle N, the next address is on ireq in cycle N+1.
- Without bypass: data_ok at N gives dataF.valid at N+1 (FIFO latency 1).
- Redirect at cycle N (state REQ, no data_ok):
  - The squashed response is never visible on dataF.
  - The first redirect_pc request is issued the cycle after the squashed data_ok.
- Full FIFO: state goes IDLE. A dequeue at cycle N re-enters REQ at N+1.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count==0, state==REQ, data_ok=1 and no redirect, dataF presents {req_addr, iresp.data} combinationally in the same cycle.
  - If deq_ready is also 1, the entry is not enqueued.
- FETCH_BYPASS_EN undefined: dataF is driven only from FIFO registers; no combinational path from iresp to dataF.

## Test plan
- Reset release, data_ok every cycle, deq_ready=1 → ireq.addr 0x8000_0000, 0x8000_0004, 0x8000_0008; dataF.pc follows one cycle later, in order.
- deq_ready=0, QDEPTH=4 → 4 entries (pcs 0x8000_0000..0x8000_000C), occupancy=4, then ireq.valid=0. One dequeue → addr 0x8000_0010 requested next cycle.
- Redirect to 0x8000_1000 while a request to 0x8000_0008 is pending (data_ok 3 cycles later) → addr stays 0x8000_0008 until data_ok, response dropped, FIFO empty, next addr 0x8000_1000.
- Redirect and data_ok in the same cycle, FIFO holding 2 entries with deq_ready=1 → head delivered, occupancy 0 next cycle, response discarded, next addr = redirect_pc.
- Reset asserted while state=REQ with count=3 → ireq.valid, dataF.valid and occupancy all 0 immediately; refetch from RESET_PC after release.
- FETCH_BYPASS_EN, empty FIFO, data_ok with deq_ready=1 → dataF.valid=1 in the same cycle with raw_instr=iresp.data; occupancy stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding-request bus FSM feeding a QDEPTH-entry FIFO drained by decode.
// Optional FETCH_BYPASS_EN: an empty FIFO forwards the bus response to dataF in the same cycle.
module fetch_queue #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   output logic                        o_ireq_valid,
   output logic [63:0]                 o_ireq_addr,
   input  logic                        i_iresp_data_ok,
   input  logic [31:0]                 i_iresp_data,
   input  logic                        i_redirect,
   input  logic [63:0]                 i_redirect_pc,
   output logic                        o_dataF_valid,
   output logic [63:0]                 o_dataF_pc,
   output logic [31:0]                 o_dataF_raw_instr,
   input  logic                        i_deq_ready,
   output logic [$clog2(QDEPTH+1)-1:0] o_occupancy
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH+1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]    r_state;
   logic [63:0]   r_pc;
   logic [63:0]   r_req_addr;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [63:0]   r_mem_pc    [QDEPTH];
   logic [31:0]   r_mem_instr [QDEPTH];

   logic          w_fifo_vld;
   logic          w_resp_acc;
   logic          w_byp;
   logic          w_deq;
   logic          w_enq;
   logic [CW-1:0] w_count_nx;
   logic          w_room_nx;

   assign w_fifo_vld = (r_count != '0);
   // A response is kept only when it belongs to the current (unsquashed) request.
   assign w_resp_acc = (r_state == S_REQ) && i_iresp_data_ok && !i_redirect;
`ifdef FETCH_BYPASS_EN
   assign w_byp = w_resp_acc && (r_count == '0);
`else
   assign w_byp = 1'b0;
`endif
   assign w_deq = w_fifo_vld && i_deq_ready;
   assign w_enq = w_resp_acc && !(w_byp && i_deq_ready);

   always_comb begin
      w_count_nx = r_count;
      if (w_enq && !w_deq)
         w_count_nx = r_count + CW'(1);
      else if (!w_enq && w_deq)
         w_count_nx = r_count - CW'(1);
   end

   assign w_room_nx = (w_count_nx < CW'(QDEPTH));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_redirect) begin
                  r_pc       <= i_redirect_pc;
                  r_req_addr <= i_redirect_pc;
                  r_state    <= S_REQ;
               end else if (w_room_nx) begin
                  r_req_addr <= r_pc;
                  r_state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_redirect) begin
                  r_pc <= i_redirect_pc;
                  if (i_iresp_data_ok)
                     r_req_addr <= i_redirect_pc;
                  else
                     r_state <= S_DROP;
               end else if (i_iresp_data_ok) begin
                  r_pc <= r_req_addr + 64'd4;
                  if (w_room_nx)
                     r_req_addr <= r_req_addr + 64'd4;
                  else
                     r_state <= S_IDLE;
               end
            end
            S_DROP: begin
               if (i_redirect)
                  r_pc <= i_redirect_pc;
               // Squashed response retires; refetch from the newest target.
               if (i_iresp_data_ok) begin
                  r_req_addr <= i_redirect ? i_redirect_pc : r_pc;
                  r_state    <= S_REQ;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_redirect) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + PW'(1);
         if (w_deq) r_head <= r_head + PW'(1);
         r_count <= w_count_nx;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_mem_pc[r_tail]    <= r_req_addr;
         r_mem_instr[r_tail] <= i_iresp_data;
      end
   end

   assign o_ireq_valid = (r_state != S_IDLE);
   assign o_ireq_addr  = r_req_addr;
   assign o_occupancy  = r_count;

   // Empty-FIFO fields read as zero so stale storage never leaks onto dataF.
   always_comb begin
      o_dataF_valid     = w_fifo_vld;
      o_dataF_pc        = w_fifo_vld ? r_mem_pc[r_head] : 64'd0;
      o_dataF_raw_instr = w_fifo_vld ? r_mem_instr[r_head] : 32'd0;
      if (w_byp) begin
         o_dataF_valid     = 1'b1;
         o_dataF_pc        = r_req_addr;
         o_dataF_raw_instr = i_iresp_data;
      end
   end
endmodule
